// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if: counter sample stream in, checker status out
interface count_seq_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 valid;
    logic [WIDTH-1:0]     q;
    logic                 locked;
    logic                 dir;
    logic [WIDTH-1:0]     expected;
    logic                 err;
    logic                 wrap;
    logic [ERR_CNT_W-1:0] err_count;
    modport master (output valid, q, input locked, dir, expected, err, wrap, err_count);
    modport slave  (input valid, q, output locked, dir, expected, err, wrap, err_count);
endinterface

// File: rtl/count_seq_checker.sv
// count_seq_checker: learns counter direction from samples, then flags every deviation
module count_seq_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_LEN  = 2,
    parameter int ERR_CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    count_seq_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
    state_t               state, state_n;
    logic [WIDTH-1:0]     last, last_n, expected_n;
    logic [2:0]           run, run_n;
    logic                 cand_dir, cand_n, dir_n, locked_n, err_n, wrap_n, up, dn;
    logic [ERR_CNT_W-1:0] cnt_n;
    assign up = bus.q == last + WIDTH'(1);
    assign dn = bus.q == last - WIDTH'(1);
    always_comb begin
        state_n  = state;
        last_n   = last;
        run_n    = run;
        cand_n   = cand_dir;
        dir_n    = bus.dir;
        locked_n = bus.locked;
        err_n    = 1'b0;
        wrap_n   = 1'b0;
        cnt_n    = bus.err_count;
        if (bus.valid) begin
            case (state)
                IDLE: begin
                    last_n  = bus.q;
                    run_n   = 3'd0;
                    state_n = ACQ;
                end
                ACQ: begin
                    run_n  = !(up || dn) ? 3'd0 : (run != 3'd0 && up == cand_dir) ? run + 3'd1 : 3'd1;
                    cand_n = (up || dn) ? up : cand_dir;
                    last_n = bus.q;
                    if (run_n == 3'(LOCK_LEN)) begin
                        dir_n    = up;
                        locked_n = 1'b1;
                        state_n  = LOCKED;
                    end
                end
                LOCKED: begin
                    last_n = bus.q;
                    if (bus.q == bus.expected) begin
                        wrap_n = bus.dir ? bus.q == '0 : bus.q == '1;
                    end else begin
                        // mismatched sample becomes the new acquisition base
                        err_n    = 1'b1;
                        cnt_n    = &bus.err_count ? bus.err_count : bus.err_count + ERR_CNT_W'(1);
                        locked_n = 1'b0;
                        run_n    = 3'd0;
                        state_n  = ACQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        expected_n = dir_n ? last_n + WIDTH'(1) : last_n - WIDTH'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last          <= '0;
            run           <= 3'd0;
            cand_dir      <= 1'b1;
            bus.dir       <= 1'b1;
            bus.locked    <= 1'b0;
            bus.expected  <= WIDTH'(1);
            bus.err       <= 1'b0;
            bus.wrap      <= 1'b0;
            bus.err_count <= '0;
        end else begin
            state         <= state_n;
            last          <= last_n;
            run           <= run_n;
            cand_dir      <= cand_n;
            bus.dir       <= dir_n;
            bus.locked    <= locked_n;
            bus.expected  <= expected_n;
            bus.err       <= err_n;
            bus.wrap      <= wrap_n;
            bus.err_count <= cnt_n;
        end
    end
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: scenario tasks against a step-history reference model
module tb_count_seq_checker;
    localparam int LOCK_LEN = 2;
    localparam logic [25:0] RST_VEC = 26'b0_1_0001_0_0_00000000_0_1_0001_0_0_00;
    logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
    logic [3:0] q = 4'd0;
    int total = 0, bad = 0;
    bit m_started, m_locked, m_dir, m_err, m_wrap;
    int m_last, m_cnt8, m_cnt2;
    int steps[$];
    logic [25:0] ev;
    logic [25:0] obs;
    always #5 clk = ~clk;
    count_seq_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) b8 ();
    count_seq_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) b2 ();
    assign b8.valid = valid;
    assign b8.q     = q;
    assign b2.valid = valid;
    assign b2.q     = q;
    count_seq_checker #(.WIDTH(4), .LOCK_LEN(LOCK_LEN), .ERR_CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    count_seq_checker #(.WIDTH(4), .LOCK_LEN(LOCK_LEN), .ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    assign obs = {b8.locked, b8.dir, b8.expected, b8.err, b8.wrap, b8.err_count,
                  b2.locked, b2.dir, b2.expected, b2.err, b2.wrap, b2.err_count};

    // Lock = the trailing run of identical nonzero steps since the base reaches LOCK_LEN.
    task automatic cyc(input bit r, input bit v, input int qq);
        int s, k, e, qv;
        qv = qq & 15;
        rst = r; valid = v; q = 4'(qv);
        @(posedge clk);
        m_err = 0; m_wrap = 0;
        if (r) begin
            m_started = 0; m_locked = 0; m_dir = 1; m_last = 0; m_cnt8 = 0; m_cnt2 = 0;
            steps.delete();
        end else if (v) begin
            if (!m_started) begin
                m_started = 1; m_last = qv; steps.delete();
            end else if (!m_locked) begin
                s = (qv == (m_last + 1) % 16) ? 1 : (qv == (m_last + 15) % 16) ? -1 : 0;
                steps.push_back(s);
                m_last = qv;
                k = 0;
                for (int i = steps.size() - 1; i >= 0 && s != 0 && steps[i] == s; i--) k++;
                if (k == LOCK_LEN) begin m_locked = 1; m_dir = (s == 1); end
            end else begin
                e = m_dir ? (m_last + 1) % 16 : (m_last + 15) % 16;
                if (qv == e) m_wrap = m_dir ? (qv == 0) : (qv == 15);
                else begin
                    m_err = 1; m_locked = 0; steps.delete();
                    m_cnt8 = m_cnt8 < 255 ? m_cnt8 + 1 : 255;
                    m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : 3;
                end
                m_last = qv;
            end
        end
        e = m_dir ? (m_last + 1) % 16 : (m_last + 15) % 16;
        ev = {m_locked, m_dir, 4'(e), m_err, m_wrap, 8'(m_cnt8), m_locked, m_dir, 4'(e), m_err, m_wrap, 2'(m_cnt2)};
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 1, 5);
        cyc(1, 0, 0);
        total++;
        if (obs !== RST_VEC) begin bad++; $display("FAIL reset got=%b want=%b", obs, RST_VEC); end
        total++;
        if (obs !== ev) begin bad++; $display("FAIL reset_model got=%b want=%b", obs, ev); end
    endtask

    task automatic test_up_wrap();
        int nw = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 18; i++) begin
            cyc(0, 1, i % 16);
            nw += int'(b8.wrap);
            total++;
            if (obs !== ev) begin bad++; $display("FAIL up_wrap[%0d] got=%b want=%b", i, obs, ev); end
            if (i == 1) begin
                total++;
                if (b8.locked !== 1'b0) begin bad++; $display("FAIL up_early_lock got=%b want=0", b8.locked); end
            end
            if (i == 2) begin
                total++;
                if ({b8.locked, b8.dir} !== 2'b11) begin bad++; $display("FAIL up_lock got=%b want=11", {b8.locked, b8.dir}); end
            end
            if (i == 16) begin
                total++;
                if (b8.wrap !== 1'b1) begin bad++; $display("FAIL up_wrap_pulse got=%b want=1", b8.wrap); end
            end
        end
        total++;
        if (nw != 1) begin bad++; $display("FAIL up_wrap_count got=%0d want=1", nw); end
        total++;
        if (b8.err_count !== 8'd0) begin bad++; $display("FAIL up_errcnt got=%0d want=0", b8.err_count); end
    endtask

    task automatic test_down_wrap();
        int seq[5] = '{2, 1, 0, 15, 14};
        int ne = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, seq[i]);
            ne += int'(b8.err);
            total++;
            if (obs !== ev) begin bad++; $display("FAIL down[%0d] got=%b want=%b", i, obs, ev); end
            if (i == 2) begin
                total++;
                if ({b8.locked, b8.dir} !== 2'b10) begin bad++; $display("FAIL down_lock got=%b want=10", {b8.locked, b8.dir}); end
            end
            if (i == 3) begin
                total++;
                if (b8.wrap !== 1'b1) begin bad++; $display("FAIL down_wrap got=%b want=1", b8.wrap); end
            end
        end
        total++;
        if (ne != 0) begin bad++; $display("FAIL down_err got=%0d want=0", ne); end
    endtask

    task automatic test_err_relock();
        int seq[7] = '{3, 4, 5, 6, 9, 10, 11};
        int ne = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, seq[i]);
            ne += int'(b8.err);
            total++;
            if (obs !== ev) begin bad++; $display("FAIL err_relock[%0d] got=%b want=%b", i, obs, ev); end
            if (i == 4) begin
                total++;
                if ({b8.err, b8.locked, b8.err_count} !== {2'b10, 8'd1}) begin
                    bad++; $display("FAIL err_pulse got=%b/%b/%0d want=1/0/1", b8.err, b8.locked, b8.err_count);
                end
            end
            if (i == 5 || i == 6) begin
                total++;
                if (b8.locked !== (i == 6)) begin bad++; $display("FAIL relock[%0d] got=%b want=%b", i, b8.locked, i == 6); end
            end
        end
        total++;
        if (ne != 1) begin bad++; $display("FAIL err_once got=%0d want=1", ne); end
    endtask

    task automatic test_zigzag();
        int seq[5] = '{3, 4, 3, 4, 3};
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, seq[i]);
            total++;
            if (obs !== ev || b8.locked !== 1'b0 || b8.err !== 1'b0 || dut8.run > 3'd1) begin
                bad++; $display("FAIL zigzag[%0d] got=%b run=%0d want=%b run<=1", i, obs, dut8.run, ev);
            end
        end
    endtask

    task automatic test_gaps_sat();
        int want2[5] = '{1, 2, 3, 3, 3};
        int cur, mism;
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, i);
            total++;
            if (obs !== ev) begin bad++; $display("FAIL gaps[%0d] got=%b want=%b", i, obs, ev); end
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                cyc(0, 0, int'($urandom));
                total++;
                if (obs !== ev) begin bad++; $display("FAIL gap_idle[%0d] got=%b want=%b", i, obs, ev); end
            end
        end
        cur = 4;
        for (int k = 0; k < 5; k++) begin
            mism = (cur + 7) % 16;
            cyc(0, 1, mism);
            total++;
            if ({b2.err, b2.err_count, b8.err_count} !== {1'b1, 2'(want2[k]), 8'(k + 1)}) begin
                bad++; $display("FAIL sat[%0d] got=%b/%0d/%0d want=1/%0d/%0d", k, b2.err, b2.err_count, b8.err_count, want2[k], k + 1);
            end
            cyc(0, 1, mism + 1);
            cyc(0, 1, mism + 2);
            total++;
            if (obs !== ev || b2.locked !== 1'b1) begin bad++; $display("FAIL sat_relock[%0d] got=%b want=%b", k, obs, ev); end
            cur = (mism + 2) % 16;
        end
    endtask

    task automatic test_reset_midlock();
        cyc(1, 0, 0);
        cyc(0, 1, 4);
        cyc(0, 1, 5);
        cyc(0, 1, 6);
        total++;
        if (b8.locked !== 1'b1) begin bad++; $display("FAIL mid_prelock got=%b want=1", b8.locked); end
        cyc(1, 1, 7);
        total++;
        if (obs !== RST_VEC) begin bad++; $display("FAIL mid_reset got=%b want=%b", obs, RST_VEC); end
        cyc(0, 1, 9);
        total++;
        if ({b8.locked, b8.expected} !== {1'b0, 4'd10}) begin bad++; $display("FAIL mid_base got=%b/%0d want=0/10", b8.locked, b8.expected); end
        cyc(0, 1, 10);
        cyc(0, 1, 11);
        total++;
        if (obs !== ev || b8.locked !== 1'b1) begin bad++; $display("FAIL mid_relock got=%b want=%b", obs, ev); end
    endtask

    task automatic test_back_to_back_random();
        int cur, d;
        bit v;
        cyc(1, 0, 0);
        cur = int'($urandom_range(0, 15));
        d = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) d = -d;
            v = (i < 300) || ($urandom_range(0, 3) != 0);
            if (v) cur = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : (cur + d + 16) % 16;
            cyc(0, v, v ? cur : int'($urandom));
            total++;
            if (obs !== ev) begin bad++; $display("FAIL random[%0d] got=%b want=%b", i, obs, ev); end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_err_relock();
        test_zigzag();
        test_gaps_sat();
        test_reset_midlock();
        test_back_to_back_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
